// File: rtl/pattern_detect_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Optional idle-input abort is enabled with DETECT_TIMEOUT_EN.
package pattern_detect_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int MAXLEN_DEF = 8;
   localparam int LENW       = $clog2(MAXLEN_DEF + 1);

   // Length 0 is meaningless, so it is treated as a single-bit pattern.
   function automatic int clamp_len(input int len, input int maxlen);
      if (len < 1)
         return 1;
      else if (len > maxlen)
         return maxlen;
      else
         return len;
   endfunction

endpackage

// File: rtl/pattern_shift_match.sv
// History shift register, bits-seen counter and masked pattern compare.
// Raises match_hit in the cycle the completing bit is sampled.
module pattern_shift_match
   import pattern_detect_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_DEF,
   parameter int LW     = $clog2(MAXLEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift_en,
   input  logic              in_bit,
   input  logic              overlap,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LW-1:0]     len,
   output logic              match_hit
);

   logic [MAXLEN-1:0] hist;
   logic [MAXLEN-1:0] hist_nxt;
   logic [MAXLEN-1:0] mask;
   logic [LW-1:0]     seen;
   logic [LW:0]       seen_p1;

   always_comb begin
      hist_nxt = {hist[MAXLEN-2:0], in_bit};
      mask     = '0;
      for (int i = 0; i < MAXLEN; i++)
         mask[i] = (i < int'(len));
      seen_p1   = {1'b0, seen} + (LW+1)'(1);
      match_hit = shift_en
               && (((hist_nxt ^ pattern) & mask) == '0)
               && (seen_p1 >= {1'b0, len});
   end

   // Non-overlapping mode forgets the bits of a completed match.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
         seen <= '0;
      end else if (clear) begin
         hist <= '0;
         seen <= '0;
      end else if (shift_en) begin
         hist <= hist_nxt;
         if (match_hit && !overlap)
            seen <= '0;
         else if (seen != LW'(MAXLEN))
            seen <= seen + 1'b1;
      end
   end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Config/arm/count controller around the serial pattern matcher.
// Define DETECT_TIMEOUT_EN to add the idle-input abort and timeout port.
module pattern_detect_ctrl
   import pattern_detect_pkg::*;
#(
   parameter int                MAXLEN      = MAXLEN_DEF,
   parameter int                CNTW        = 8,
   parameter logic [MAXLEN-1:0] DEF_PATTERN = MAXLEN'(8'b0000_1011),
   parameter int                DEF_LEN     = 4,
   parameter int                TIMEOUT_CYC = 255,
   localparam int               LW          = $clog2(MAXLEN + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [MAXLEN-1:0] cfg_pattern,
   input  logic [LW-1:0]     cfg_len,
   input  logic              cfg_overlap,
   input  logic [CNTW-1:0]   cfg_target,
   input  logic              start,
   input  logic              stop,
   input  logic              in_valid,
   input  logic              in,
   output logic              q,
   output logic [CNTW-1:0]   match_count,
   output logic              busy,
   output logic              done
`ifdef DETECT_TIMEOUT_EN
  ,output logic              timeout
`endif
);

   state_t            state;
   logic [MAXLEN-1:0] pat_r;
   logic [LW-1:0]     len_r;
   logic              ovl_r;
   logic [CNTW-1:0]   tgt_r;
   logic              arm;
   logic              shift_en;
   logic              match_hit;
   logic              hit_last;

`ifdef DETECT_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tcnt;
`endif

   assign cfg_ready = (state == IDLE);
   assign busy      = (state == ARMED);
   assign arm       = (state == IDLE) && start && !cfg_valid;
   assign shift_en  = (state == ARMED) && in_valid && !stop;
   assign hit_last  = (tgt_r != '0)
                   && ((match_count + 1'b1) == tgt_r);

   pattern_shift_match #(
      .MAXLEN (MAXLEN),
      .LW     (LW)
   ) u_match (
      .clk       (clk),
      .rst       (rst),
      .clear     (arm),
      .shift_en  (shift_en),
      .in_bit    (in),
      .overlap   (ovl_r),
      .pattern   (pat_r),
      .len       (len_r),
      .match_hit (match_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pat_r       <= DEF_PATTERN;
         len_r       <= LW'(clamp_len(DEF_LEN, MAXLEN));
         ovl_r       <= 1'b1;
         tgt_r       <= '0;
         q           <= 1'b0;
         match_count <= '0;
         done        <= 1'b0;
`ifdef DETECT_TIMEOUT_EN
         timeout     <= 1'b0;
         tcnt        <= '0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               q <= 1'b0;
               if (cfg_valid) begin
                  pat_r <= cfg_pattern;
                  len_r <= LW'(clamp_len(int'(cfg_len), MAXLEN));
                  ovl_r <= cfg_overlap;
                  tgt_r <= cfg_target;
               end else if (start) begin
                  state       <= ARMED;
                  match_count <= '0;
`ifdef DETECT_TIMEOUT_EN
                  timeout     <= 1'b0;
                  tcnt        <= '0;
`endif
               end
            end
            ARMED: begin
               if (stop) begin
                  state <= IDLE;
                  q     <= 1'b0;
               end else begin
                  q <= match_hit;
                  if (match_hit) begin
                     if (match_count != '1)
                        match_count <= match_count + 1'b1;
                     if (hit_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end
                  end
`ifdef DETECT_TIMEOUT_EN
                  if (in_valid) begin
                     tcnt <= '0;
                  end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     timeout <= 1'b1;
                     tcnt    <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
`endif
               end
            end
            DONE: begin
               q     <= 1'b0;
               state <= IDLE;
            end
            default: begin
               q     <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pattern_detect_ctrl.md
Name: pattern_detect_ctrl

Overview:
Programmable controller for the team's Moore-style serial pattern detector. It accepts a pattern, length, overlap mode and target count over a valid/ready config port, then arms on start. It runs detection on the gated serial stream, counting matches and finishing when the target is reached. It sits between the host/config logic and the serial data source, and replaces hard-coded single-pattern FSMs.

Parameters:
MAXLEN, 8, maximum pattern length in bits
CNTW, 8, width of match counter and target
DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB = last bit received)
DEF_LEN, 4, pattern length loaded at reset
TIMEOUT_CYC, 255, idle-input abort threshold (only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_pattern  in  MAXLEN  pattern bits, LSB = most recent bit
cfg_len  in  $clog2(MAXLEN+1)  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  in  CNTW  matches before done; 0 = free-run
start  in  1  arm request
stop  in  1  abort request
in_valid  in  1  qualifies in
in  in  1  serial data bit
q  out  1  Moore match output, one cycle per match
match_count  out  CNTW  matches since last start
busy  out  1  high in ARMED
done  out  1  one-cycle pulse on target reached (or timeout)
timeout  out  1  sticky abort flag (only with the optional feature)

Behaviour:
- Reset: state = IDLE. Pattern, length and overlap load DEF_PATTERN, DEF_LEN and 1. Target = 0. q, match_count, busy, done and timeout = 0. History shift register and bits_seen = 0.
- States: IDLE, ARMED, DONE.
- IDLE:
  - cfg_ready = 1. cfg_valid loads all config registers.
  - cfg_len is clamped: 0 -> 1, >MAXLEN -> MAXLEN.
  - start with cfg_valid low -> ARMED. This clears match_count, history, bits_seen and timeout.
  - start in the same cycle as cfg_valid is ignored; config wins.
- ARMED:
  - cfg_ready = 0 and busy = 1.
  - Each cycle with in_valid: history <= {history[MAXLEN-2:0], in}, and bits_seen increments, saturating at MAXLEN.
  - A match exists when the updated low cfg_len bits of history equal the pattern and bits_seen+1 >= len.
  - On a match edge: q <= 1 next cycle, and match_count increments (saturates in free-run).
  - Overlap = 0: bits_seen <= 0 on a match. Overlap = 1: history is retained.
  - in_valid low: no shift, q <= 0.
  - If match_count+1 == target (target != 0) -> DONE.
  - stop -> IDLE with no done. match_count holds and q <= 0. stop beats a simultaneous match; that match is not counted.
  - start while ARMED is ignored.
- DONE: lasts one cycle. done = 1, and q still shows the final match. Then -> IDLE. match_count holds until the next start.
- q is registered (Moore). Latency is 1 cycle from sampling the completing bit to q = 1.
- rst in any state returns to the reset values above, including config.

Optional Feature:
DETECT_TIMEOUT_EN:
- Defined: a counter in ARMED clears on in_valid and increments otherwise. When it reaches TIMEOUT_CYC, the block goes to DONE, and timeout = 1 stays high until the next start or rst.
- Undefined: no counter and no timeout port. ARMED waits indefinitely.

Decomposition:
- Package pattern_detect_pkg holds:
  - the state enum (IDLE/ARMED/DONE)
  - the length-width constant
  - the length clamp function
- One sub-module, pattern_shift_match, holds the history shift register, bits_seen and the masked compare. It outputs a single-cycle match_hit. The controller FSM, counter and optional timeout live in the top.

Test Plan:
- After reset, start and stream 1,0,1,1,0,1,1 (overlap=1, target=0): q pulses after bits 4 and 7, match_count=2.
- Config pattern 1011, len 4, overlap=0, then the same stream: q pulses only after bit 4, match_count=1.
- Target=2, overlap=1, stream 1011011: DONE entered after bit 7, done=1 for one cycle together with q=1, then busy=0 and match_count stays 2.
- in_valid low between every bit of 1011: the match is still detected, and q is never high during gap cycles.
- stop asserted on the cycle bit 4 completes the match: no q pulse, match_count=0, state returns to IDLE, done stays 0.
- cfg_valid with cfg_len=0 and pattern 1: every 1 bit produces a q pulse. cfg_valid asserted while ARMED: cfg_ready=0 and the config is unchanged.
- DETECT_TIMEOUT_EN: with TIMEOUT_CYC=5, start, then in_valid=0 for 5 cycles gives done=1 and timeout=1.
